// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, in-order imem request/response tracking,
// prefetch FIFO toward decode, and redirect flush with stale-response dropping.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  // Stale requests can pile up across several quick redirects, so the drop
  // counter gets extra headroom beyond one FIFO's worth of credits.
  localparam int DW = CW + 4;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   r_pc;
  logic [CW-1:0] r_occ;
  logic [CW-1:0] r_outstanding;
  logic [DW-1:0] r_drop_cnt;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_pcq_wr;
  logic [PW-1:0] r_pcq_rd;
  logic [31:0]   r_fifo_inst [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
  logic [31:0]   r_pcq       [FIFO_DEPTH];

  logic [CW:0]   w_credit_used;
  logic          w_req_valid;
  logic          w_hs;
  logic          w_rsp_drop;
  logic          w_push;
  logic          w_pop;
  logic          w_unused;

  assign w_unused      = &{1'b0, redirect_pc[1:0]};
  assign w_credit_used = {1'b0, r_occ} + {1'b0, r_outstanding};
  assign w_req_valid   = !rst && !redirect_valid && (w_credit_used < DEPTH_C);
  assign w_hs          = w_req_valid && imem_req_ready;
  assign w_rsp_drop    = imem_rsp_valid && (r_drop_cnt != '0);
  assign w_push        = !rst && imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
  assign w_pop         = inst_valid && inst_ready && !redirect_valid;

  // r_outstanding counts only live requests; on redirect they all move into
  // r_drop_cnt, and responses always retire stale requests first (in order).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_occ         <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_pcq_wr      <= '0;
      r_pcq_rd      <= '0;
    end else if (redirect_valid) begin
      r_pc          <= {redirect_pc[31:2], 2'b00};
      r_occ         <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= r_drop_cnt + DW'(r_outstanding) - DW'(imem_rsp_valid);
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_pcq_wr      <= '0;
      r_pcq_rd      <= '0;
    end else begin
      if (w_hs) begin
        r_pc     <= r_pc + 32'd4;
        r_pcq_wr <= r_pcq_wr + PW'(1);
      end
      if (w_rsp_drop) begin
        r_drop_cnt <= r_drop_cnt - DW'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        r_pcq_rd <= r_pcq_rd + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_outstanding <= r_outstanding + CW'(w_hs) - CW'(w_push);
      r_occ         <= r_occ + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_pcq[r_pcq_wr] <= r_pc;
    end
    if (w_push) begin
      r_fifo_inst[r_wr_ptr] <= imem_rsp_data;
      r_fifo_pc[r_wr_ptr]   <= r_pcq[r_pcq_rd];
    end
  end

  // Empty FIFO presents all-zero fields so the decoder falls to its default.
  assign inst_valid     = (r_occ != '0);
  assign inst           = inst_valid ? r_fifo_inst[r_rd_ptr] : 32'h0;
  assign inst_pc        = inst_valid ? r_fifo_pc[r_rd_ptr] : 32'h0;
  assign opcode         = inst[6:0];
  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign busy           = (r_outstanding != '0) || (r_drop_cnt != '0);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: in-order memory model with variable
// latency, delivery log, and immediate-assertion checks.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0100),
    .FIFO_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .opcode        (opcode),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] acc_q[$];
  logic [31:0] dpc_q[$];
  logic [31:0] dinst_q[$];
  int          cyc = 0;
  int          lat = 1;
  int          n_checks = 0;
  int          n_err = 0;
  logic [31:0] w;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[27:0], 4'h0} ^ 32'h0000_0053 ^ {25'h0, a[8:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    acc_q.delete();
    dpc_q.delete();
    dinst_q.delete();
  endtask

  // One clock: log handshakes, advance, then present any due memory response.
  task automatic cycle();
    pend_t p;
    #1;
    if (imem_req_valid && imem_req_ready) begin
      acc_q.push_back(imem_req_addr);
      p.due  = cyc + lat;
      p.data = mem_word(imem_req_addr);
      pend_q.push_back(p);
    end
    if (inst_valid && inst_ready) begin
      dpc_q.push_back(inst_pc);
      dinst_q.push_back(inst);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (!rst && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend_q[0].data;
      void'(pend_q.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    pend_q.delete();
    clear_logs();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_deliv(input string tag, input int n);
    for (int i = 0; i < 60 && dpc_q.size() < n; i++) cycle();
    chk(tag, 32'(dpc_q.size()), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_addr", imem_req_addr, 32'h100);

    // Reset fetch: zero-wait memory, decode always ready
    rst = 1'b0;
    #1;
    chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t1_req_addr", imem_req_addr, 32'h100);
    cycle();
    chk("t1_valid_c2", 32'(inst_valid), 32'd0);
    cycle();
    w = mem_word(32'h100);
    chk("t1_valid_c3", 32'(inst_valid), 32'd1);
    chk("t1_pc_first", inst_pc, 32'h100);
    chk("t1_inst_first", inst, w);
    chk("t1_opcode_first", 32'(opcode), {25'h0, w[6:0]});
    wait_deliv("t1_count", 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t1_pc%0d", k), dpc_q[k], 32'h100 + 32'(4 * k));
      chk($sformatf("t1_inst%0d", k), dinst_q[k], mem_word(32'h100 + 32'(4 * k)));
      chk($sformatf("t1_addr%0d", k), acc_q[k], 32'h100 + 32'(4 * k));
    end

    // Decode stall: exactly FIFO_DEPTH requests, head held stable
    inst_ready = 1'b0;
    do_reset();
    repeat (10) cycle();
    chk("t2_accepted", 32'(acc_q.size()), 32'd2);
    chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t2_inst_valid", 32'(inst_valid), 32'd1);
    chk("t2_inst_pc", inst_pc, 32'h100);
    chk("t2_inst", inst, mem_word(32'h100));
    inst_ready = 1'b1;
    wait_deliv("t2_count", 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_pc%0d", k), dpc_q[k], 32'h100 + 32'(4 * k));
      chk($sformatf("t2_inst%0d", k), dinst_q[k], mem_word(32'h100 + 32'(4 * k)));
    end

    // Redirect with two in-flight fetches, memory latency 3
    lat = 3;
    do_reset();
    cycle();
    cycle();
    chk("t3_busy_pre", 32'(busy), 32'd1);
    chk("t3_req_blocked", 32'(imem_req_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2003;
    imem_req_ready = 1'b0;
    #1;
    chk("t3_redir_noreq", 32'(imem_req_valid), 32'd0);
    cycle();
    redirect_valid = 1'b0;
    #1;
    chk("t3_addr", imem_req_addr, 32'h2000);
    chk("t3_req_held", 32'(imem_req_valid), 32'd1);
    chk("t3_busy_drop2", 32'(busy), 32'd1);
    cycle();
    chk("t3_busy_drop1", 32'(busy), 32'd1);
    cycle();
    chk("t3_busy_fall", 32'(busy), 32'd0);
    chk("t3_no_stale", 32'(inst_valid), 32'd0);
    imem_req_ready = 1'b1;
    clear_logs();
    wait_deliv("t3_count", 1);
    chk("t3_first_acc", acc_q[0], 32'h2000);
    chk("t3_first_pc", dpc_q[0], 32'h2000);
    chk("t3_first_inst", dinst_q[0], mem_word(32'h2000));

    // Redirect coinciding with a response and a pop, FIFO holding one entry
    lat = 1;
    inst_ready = 1'b0;
    do_reset();
    cycle();
    cycle();
    chk("t4_pre_valid", 32'(inst_valid), 32'd1);
    chk("t4_pre_rsp", 32'(imem_rsp_valid), 32'd1);
    chk("t4_pre_busy", 32'(busy), 32'd1);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3000;
    cycle();
    redirect_valid = 1'b0;
    #1;
    chk("t4_flush_valid", 32'(inst_valid), 32'd0);
    chk("t4_drop_busy", 32'(busy), 32'd0);
    chk("t4_addr", imem_req_addr, 32'h3000);
    clear_logs();
    wait_deliv("t4_count", 2);
    chk("t4_pc0", dpc_q[0], 32'h3000);
    chk("t4_pc1", dpc_q[1], 32'h3004);

    // PC wrap under memory backpressure (misaligned target bits ignored)
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    cycle();
    redirect_valid = 1'b0;
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk($sformatf("t5_hold_addr%0d", i), imem_req_addr, 32'hFFFF_FFFC);
      chk($sformatf("t5_hold_valid%0d", i), 32'(imem_req_valid), 32'd1);
    end
    imem_req_ready = 1'b1;
    cycle();
    chk("t5_wrap_addr", imem_req_addr, 32'h0000_0000);
    wait_deliv("t5_count", 2);
    chk("t5_acc0", acc_q[0], 32'hFFFF_FFFC);
    chk("t5_acc1", acc_q[1], 32'h0000_0000);
    chk("t5_pc0", dpc_q[0], 32'hFFFF_FFFC);
    chk("t5_pc1", dpc_q[1], 32'h0000_0000);

    // Asynchronous reset between clock edges with the FIFO full
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4000;
    cycle();
    redirect_valid = 1'b0;
    repeat (6) cycle();
    chk("t6_full_valid", 32'(inst_valid), 32'd1);
    chk("t6_full_pc", inst_pc, 32'h4000);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_inst", inst, 32'h0);
    chk("t6_rst_inst_pc", inst_pc, 32'h0);
    chk("t6_rst_opcode", 32'(opcode), 32'h0);
    pend_q.delete();
    clear_logs();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    inst_ready = 1'b1;
    #1;
    chk("t6_restart_addr", imem_req_addr, 32'h100);
    chk("t6_restart_valid", 32'(imem_req_valid), 32'd1);
    cycle();
    cycle();
    chk("t6_restart_inst_valid", 32'(inst_valid), 32'd1);
    chk("t6_restart_pc", inst_pc, 32'h100);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
